// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if: request/ready bus of the MEM-stage data memory.
// master: Req, Write, Size, Address, writeData (+Unsigned); slave: ready, dataOut, addrErr.
interface data_ram_ctrl_if;
  logic        Req;
  logic        Write;
  logic [1:0]  Size;
  logic [31:0] Address;
  logic [31:0] writeData;
`ifdef DATA_RAM_SIGNEXT_EN
  logic        Unsigned;
`endif
  logic        ready;
  logic [31:0] dataOut;
  logic        addrErr;

  modport master (
`ifdef DATA_RAM_SIGNEXT_EN
    output Unsigned,
`endif
    output Req, Write, Size, Address, writeData,
    input  ready, dataOut, addrErr
  );

  modport slave (
`ifdef DATA_RAM_SIGNEXT_EN
    input  Unsigned,
`endif
    input  Req, Write, Size, Address, writeData,
    output ready, dataOut, addrErr
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: big-endian byte-addressed data RAM, IDLE/BUSY/DONE handshake,
// WAIT_STATES extra cycles, byte/half/word, misalign/range errors.
// Ports: CLK, RST (sync, active high), bus (data_ram_ctrl_if.slave).
// Option DATA_RAM_SIGNEXT_EN: adds bus.Unsigned, sub-word loads sign-extend when 0.
module data_ram_ctrl #(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 1
) (
  input logic            CLK,
  input logic            RST,
  data_ram_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic                        wr_q;
  logic [1:0]                  size_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 wdata_q;
  logic [DEPTH_BYTES-1:0][7:0] mem;
  logic [31:0]                 dout_q;
  logic                        err_q;

  // Operands of the access: live bus in IDLE
  // (zero wait states enter DONE straight from IDLE), latched copy otherwise.
  logic        wr_c;
  logic [1:0]  size_c;
  logic [31:0] addr_c;
  logic [31:0] wdata_c;
  logic        sx_c;

  always_comb begin
    wr_c    = wr_q;
    size_c  = size_q;
    addr_c  = addr_q;
    wdata_c = wdata_q;
    if (state == IDLE) begin
      wr_c    = bus.Write;
      size_c  = bus.Size;
      addr_c  = bus.Address;
      wdata_c = bus.writeData;
    end
  end

`ifdef DATA_RAM_SIGNEXT_EN
  logic uns_q;
  assign sx_c = (state == IDLE) ? !bus.Unsigned : !uns_q;
`else
  assign sx_c = 1'b0;
`endif

  logic [2:0]  nb;
  logic [32:0] last;
  logic        err;

  always_comb begin
    nb = 3'd4;
    unique case (1'b1)
      size_c == 2'b00: nb = 3'd1;
      size_c == 2'b01: nb = 3'd2;
      default:         nb = 3'd4;
    endcase
  end

  // Full 32-bit range check: no wrap, upper address bits count.
  assign last = {1'b0, addr_c} + {30'd0, nb} - 33'd1;
  assign err  = (size_c == 2'b11)
              | ((size_c == 2'b01) & addr_c[0])
              | ((size_c == 2'b10) & (|addr_c[1:0]))
              | (last >= 33'(DEPTH_BYTES));

  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   ld;

  assign i0 = addr_c[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  always_comb begin
    ld = {b0, b1, b2, b3};
    unique case (1'b1)
      size_c == 2'b00: ld = {{24{sx_c & b0[7]}}, b0};
      size_c == 2'b01: ld = {{16{sx_c & b0[7]}}, b0, b1};
      default:         ld = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.Req) begin
          if (WAIT_STATES == 0) begin
            state_n = DONE;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'(WAIT_STATES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_n = DONE;
        else             cnt_n   = cnt - 4'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
      mem     <= '0;
`ifdef DATA_RAM_SIGNEXT_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && bus.Req) begin
        wr_q    <= bus.Write;
        size_q  <= bus.Size;
        addr_q  <= bus.Address;
        wdata_q <= bus.writeData;
`ifdef DATA_RAM_SIGNEXT_EN
        uns_q   <= bus.Unsigned;
`endif
      end
      if (state != DONE && state_n == DONE) begin
        err_q <= err;
        if (err) begin
          dout_q <= 32'd0;
        end else if (!wr_c) begin
          dout_q <= ld;
        end else begin
          unique case (1'b1)
            size_c == 2'b00: mem[i0] <= wdata_c[7:0];
            size_c == 2'b01: begin
              mem[i0] <= wdata_c[15:8];
              mem[i1] <= wdata_c[7:0];
            end
            default: begin
              mem[i0] <= wdata_c[31:24];
              mem[i1] <= wdata_c[23:16];
              mem[i2] <= wdata_c[15:8];
              mem[i3] <= wdata_c[7:0];
            end
          endcase
        end
      end
    end
  end

  assign bus.ready   = (state == DONE);
  assign bus.dataOut = dout_q;
  assign bus.addrErr = err_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed bench with a byte-array memory model,
// per-cycle ready/data checks and literal expectations.
module tb_data_ram_ctrl;
  localparam int DEPTH = 256;
  localparam int WS    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  data_ram_ctrl_if ib ();
  data_ram_ctrl_if i0 ();
  data_ram_ctrl_if i3 ();

  data_ram_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK(clk), .RST(rst), .bus(ib)
  );
  data_ram_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u0 (
    .CLK(clk), .RST(rst), .bus(i0)
  );
  data_ram_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(3)) u3 (
    .CLK(clk), .RST(rst), .bus(i3)
  );

  logic [7:0] m [DEPTH];

  typedef struct {
    int          cyc;
    logic        chk_d;
    logic        err;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Spec-level model: n bytes big-endian starting at a, no wrap.
  function automatic void model(input logic wr, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic uns, output logic err,
                                output logic [31:0] v);
    int n;
    longint la;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    la  = longint'(a);
    err = (sz == 2'd3) || (la % n != 0) || (la + n > DEPTH);
    v   = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (wr) m[int'(la) + i] = 8'(wd >> (8 * (n - 1 - i)));
        else    v = (v << 8) | 32'(m[int'(la) + i]);
      end
      if (!wr && !uns && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
    end
  endfunction

  // Every cycle: ready must match the model's schedule; on ready,
  // addrErr and (for loads/errors) dataOut must match.
  always @(negedge clk) begin : cmp
    logic er;
    exp_t e;
    if (!rst) begin
      er = (q.size() > 0) && (q[0].cyc == cyc);
      chk("ready", 32'(ib.ready), 32'(er));
      if (er) begin
        e = q.pop_front();
        chk("addrErr", 32'(ib.addrErr), 32'(e.err));
        if (e.chk_d) chk("dataOut", ib.dataOut, e.d);
      end
    end
  end

  int r0[$];
  int r3[$];
  always @(negedge clk) begin
    if (!rst && i0.ready) r0.push_back(cyc);
    if (!rst && i3.ready) r3.push_back(cyc);
  end

  task automatic access(input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic uns, output logic [31:0] dout,
                        output logic err);
    exp_t e;
    logic me;
    logic [31:0] mv;
    bit seen;
    @(posedge clk);
    #1;
    ib.Req       = 1'b1;
    ib.Write     = wr;
    ib.Size      = sz;
    ib.Address   = a;
    ib.writeData = wd;
`ifdef DATA_RAM_SIGNEXT_EN
    ib.Unsigned  = uns;
`endif
    model(wr, sz, a, wd, uns, me, mv);
    e.cyc   = cyc + WS + 1;
    e.chk_d = !wr || me;
    e.err   = me;
    e.d     = mv;
    q.push_back(e);
    seen = 0;
    dout = 32'd0;
    err  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ib.ready) begin
        seen = 1;
        dout = ib.dataOut;
        err  = ib.addrErr;
      end
    end
    ib.Req = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: no ready for addr %h", a);
    end
  endtask

  task automatic ld(input string nm, input logic [1:0] sz,
                    input logic [31:0] a, input logic uns,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic e;
    access(1'b0, sz, a, 32'd0, uns, d, e);
    chk({nm, ".data"}, d, exp_d);
    chk({nm, ".err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic st(input string nm, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic exp_e);
    logic [31:0] d;
    logic e;
    access(1'b1, sz, a, wd, 1'b1, d, e);
    chk({nm, ".err"}, 32'(e), 32'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stuck");
  end

  initial begin
    int c;
    ib.Req = 1'b0; ib.Write = 1'b0; ib.Size = 2'd0;
    ib.Address = 32'd0; ib.writeData = 32'd0;
    i0.Req = 1'b0; i0.Write = 1'b0; i0.Size = 2'd2;
    i0.Address = 32'd0; i0.writeData = 32'd0;
    i3.Req = 1'b0; i3.Write = 1'b0; i3.Size = 2'd2;
    i3.Address = 32'd0; i3.writeData = 32'd0;
`ifdef DATA_RAM_SIGNEXT_EN
    ib.Unsigned = 1'b1;
    i0.Unsigned = 1'b1;
    i3.Unsigned = 1'b1;
`endif
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(ib.ready), 32'd0);
    chk("rst.addrErr", 32'(ib.addrErr), 32'd0);
    chk("rst.dataOut", ib.dataOut, 32'd0);

    st("st_w10", 2'd2, 32'h10, 32'h1234_5678, 1'b0);
    ld("ld_w10", 2'd2, 32'h10, 1'b1, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold.dataOut", ib.dataOut, 32'h1234_5678);
    ld("ld_b10", 2'd0, 32'h10, 1'b1, 32'h0000_0012, 1'b0);
    ld("ld_h12", 2'd1, 32'h12, 1'b1, 32'h0000_5678, 1'b0);
    st("st_b13", 2'd0, 32'h13, 32'h0000_00AB, 1'b0);
    ld("ld_w10b", 2'd2, 32'h10, 1'b1, 32'h1234_56AB, 1'b0);

    ld("ld_w11", 2'd2, 32'h11, 1'b1, 32'h0, 1'b1);
    st("st_bFE", 2'd0, 32'hFE, 32'h0000_005A, 1'b0);
    st("st_wFE", 2'd2, 32'hFE, 32'hDEAD_BEEF, 1'b1);
    ld("ld_hFE", 2'd1, 32'hFE, 1'b1, 32'h0000_5A00, 1'b0);
    st("st_wFC", 2'd2, 32'hFC, 32'hCAFE_F00D, 1'b0);
    ld("ld_wFC", 2'd2, 32'hFC, 1'b1, 32'hCAFE_F00D, 1'b0);
    ld("ld_bFF", 2'd0, 32'hFF, 1'b1, 32'h0000_000D, 1'b0);
    ld("ld_sz3", 2'd3, 32'h10, 1'b1, 32'h0, 1'b1);
    ld("ld_h11", 2'd1, 32'h11, 1'b1, 32'h0, 1'b1);
    ld("ld_w100", 2'd2, 32'h100, 1'b1, 32'h0, 1'b1);
    ld("ld_whigh", 2'd2, 32'h1000_0010, 1'b1, 32'h0, 1'b1);
    ld("ld_w10c", 2'd2, 32'h10, 1'b1, 32'h1234_56AB, 1'b0);

    st("st_b30", 2'd0, 32'h30, 32'h0000_0080, 1'b0);
    st("st_h32", 2'd1, 32'h32, 32'h0000_8001, 1'b0);
`ifdef DATA_RAM_SIGNEXT_EN
    ld("sx_b30", 2'd0, 32'h30, 1'b0, 32'hFFFF_FF80, 1'b0);
    ld("zx_b30", 2'd0, 32'h30, 1'b1, 32'h0000_0080, 1'b0);
    ld("sx_h32", 2'd1, 32'h32, 1'b0, 32'hFFFF_8001, 1'b0);
`else
    ld("zx_b30", 2'd0, 32'h30, 1'b1, 32'h0000_0080, 1'b0);
    ld("zx_h32", 2'd1, 32'h32, 1'b1, 32'h0000_8001, 1'b0);
`endif

    // Req held high on the 0- and 3-wait-state instances for 10 cycles.
    @(posedge clk);
    #1;
    c = cyc;
    i0.Req = 1'b1;
    i3.Req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    i0.Req = 1'b0;
    i3.Req = 1'b0;
    repeat (3) @(posedge clk);
    chk("ws0.count", 32'(r0.size()), 32'd5);
    chk("ws0.first", 32'(r0.size() > 0 ? r0[0] - c : -1), 32'd1);
    chk("ws0.second", 32'(r0.size() > 1 ? r0[1] - c : -1), 32'd3);
    chk("ws3.count", 32'(r3.size()), 32'd2);
    chk("ws3.first", 32'(r3.size() > 0 ? r3[0] - c : -1), 32'd4);
    chk("ws3.second", 32'(r3.size() > 1 ? r3[1] - c : -1), 32'd9);

    // Reset while the store is in BUSY: no ready, nothing committed.
    @(posedge clk);
    #1;
    ib.Req = 1'b1; ib.Write = 1'b1; ib.Size = 2'd2;
    ib.Address = 32'h20; ib.writeData = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ib.Req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    chk("rst2.dataOut", ib.dataOut, 32'd0);
    chk("rst2.addrErr", 32'(ib.addrErr), 32'd0);
    repeat (4) @(posedge clk);
    ld("ld_w20", 2'd2, 32'h20, 1'b1, 32'h0, 1'b0);
    ld("ld_w10z", 2'd2, 32'h10, 1'b1, 32'h0, 1'b0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
